// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter for the shared FIFO write port.
// Optional macro FIFO_ARB_STATS_EN builds the stat_beats accepted-beat counter.
//
// Ports:
//   clk, reset          single clock, async active-high reset
//   req_valid/req_data  per-producer valid and packed data words
//   req_ready           per-producer accept strobe
//   fifo_full           FIFO full flag, used combinationally
//   fifo_wr_en/data_in  FIFO write port
//   grant_id, busy      registered grant index, high while granting
//   stat_beats          accepted-beat counter, or zero when the macro is off
module fifo_wr_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int BURST_LEN  = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic [15:0]                   stat_beats
);

  localparam int BCW =
    (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0] LAST_BEAT =
    BCW'(BURST_LEN - 1);
  localparam logic [ID_W-1:0] LAST_ID =
    ID_W'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [ID_W-1:0] r_grant_id;
  logic [ID_W-1:0] w_grant_id_nx;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_rr_ptr_nx;
  logic [BCW-1:0]  r_beat_cnt;
  logic [BCW-1:0]  w_beat_cnt_nx;

  logic [ID_W-1:0]       w_pick;
  logic                  w_any;
  logic [NUM_REQ-1:0]    w_onehot;
  logic                  w_sel_valid;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [ID_W-1:0]       w_ptr_after;

  // Round-robin search: walk offsets from high to low so the
  // smallest offset from rr_ptr wins the last assignment.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_pick = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        w_any  = 1'b1;
      end
    end
  end

  // Granted producer's valid, data and one-hot select.
  always_comb begin
    w_onehot    = '0;
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == ID_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_sel_valid = req_valid[i];
        w_sel_data  =
          req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer moves past the producer that just finished.
  assign w_ptr_after =
    (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;

  always_comb begin
    w_state_nx    = r_state;
    w_grant_id_nx = r_grant_id;
    w_rr_ptr_nx   = r_rr_ptr;
    w_beat_cnt_nx = r_beat_cnt;
    req_ready     = '0;
    fifo_wr_en    = 1'b0;
    fifo_data_in  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nx    = S_GRANT;
          w_grant_id_nx = w_pick;
          w_beat_cnt_nx = '0;
        end
      end
      S_GRANT: begin
        req_ready    = w_onehot & {NUM_REQ{~fifo_full}};
        fifo_wr_en   = w_sel_valid & ~fifo_full;
        fifo_data_in = w_sel_data;
        if (!w_sel_valid) begin
          w_state_nx  = S_IDLE;
          w_rr_ptr_nx = w_ptr_after;
        end else if (fifo_wr_en) begin
          if (r_beat_cnt == LAST_BEAT) begin
            w_state_nx  = S_IDLE;
            w_rr_ptr_nx = w_ptr_after;
          end else begin
            w_beat_cnt_nx = r_beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_grant_id <= w_grant_id_nx;
      r_rr_ptr   <= w_rr_ptr_nx;
      r_beat_cnt <= w_beat_cnt_nx;
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state == S_GRANT);

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_stat_beats;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_beats <= '0;
    end else if (fifo_wr_en) begin
      r_stat_beats <= r_stat_beats + 16'd1;
    end
  end

  assign stat_beats = r_stat_beats;
`else
  assign stat_beats = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: random producers and FIFO occupancy checked
// against a transaction-level arbiter model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BL = 4;
  localparam int FD = 16;
  localparam int IW = $clog2(NR);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic [15:0]     stat_beats;

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .BURST_LEN (BL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .grant_id    (grant_id),
    .busy        (busy),
    .stat_beats  (stat_beats)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // producer word queues and FIFO occupancy
  logic [DW-1:0] q [NR][$];
  int occ = 0;

  // model: current owner (-1 = none), last granted, pointer, beats
  int m_own = -1;
  int m_gid = 0;
  int m_ptr = 0;
  int m_bt  = 0;
  int m_stat = 0;

  function automatic int exp_stat();
`ifdef FIFO_ARB_STATS_EN
    return m_stat;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_gid  = 0;
    m_ptr  = 0;
    m_bt   = 0;
    m_stat = 0;
  endtask

  task automatic drive_producers();
    for (int i = 0; i < NR; i++) begin
      if (q[i].size() < 6 && $urandom_range(0, 2) != 0)
        q[i].push_back(DW'($urandom));
      if (q[i].size() == 0)
        req_valid[i] = 1'b0;
      else if (req_valid[i])
        req_valid[i] = ($urandom_range(0, 15) != 0);
      else
        req_valid[i] = $urandom_range(0, 1) == 1;
      req_data[i*DW +: DW] =
        (q[i].size() != 0) ? q[i][0] : '0;
    end
    fifo_full = (occ == FD);
  endtask

  int e_rdy, e_wr, e_dat;

  task automatic expect_outputs();
    e_rdy = 0;
    e_wr  = 0;
    e_dat = 0;
    if (m_own >= 0) begin
      e_rdy = fifo_full ? 0 : (1 << m_own);
      e_wr  = (req_valid[m_own] && !fifo_full) ? 1 : 0;
      e_dat = int'(req_data[m_own*DW +: DW]);
    end
    chk("ready", 32'(req_ready), 32'(e_rdy));
    chk("wr_en", 32'(fifo_wr_en), 32'(e_wr));
    chk("data", 32'(fifo_data_in), 32'(e_dat));
    chk("busy", 32'(busy), (m_own >= 0) ? 1 : 0);
    chk("gid", 32'(grant_id), 32'(m_gid));
    chk("stat", 32'(stat_beats), 32'(exp_stat()));
  endtask

  task automatic model_step(input int rdp);
    bit rd;
    if (m_own < 0) begin
      if (req_valid != 0) begin
        for (int k = NR - 1; k >= 0; k--)
          if (req_valid[(m_ptr + k) % NR])
            m_own = (m_ptr + k) % NR;
        m_gid = m_own;
        m_bt  = 0;
      end
    end else if (!req_valid[m_own]) begin
      m_ptr = (m_own + 1) % NR;
      m_own = -1;
    end else if (e_wr != 0) begin
      void'(q[m_own].pop_front());
      m_stat = (m_stat + 1) % 65536;
      if (m_bt == BL - 1) begin
        m_ptr = (m_own + 1) % NR;
        m_own = -1;
      end else begin
        m_bt++;
      end
    end
    rd  = (occ > 0) && ($urandom_range(0, 99) < rdp);
    occ = occ + e_wr - (rd ? 1 : 0);
  endtask

  int rdp;

  initial begin
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wr", 32'(fifo_wr_en), 0);
    chk("rst_data", 32'(fifo_data_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_stat", 32'(stat_beats), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      reset = 1'b0;
      unique case ((cyc / 250) % 4)
        0: rdp = 100;
        1: rdp = 0;
        2: rdp = 30;
        default: rdp = 70;
      endcase
      drive_producers();
      #1;
      expect_outputs();
      if ((cyc % 97) == 96 && m_own >= 0) begin
        reset = 1'b1;
        #1;
        chk("mid_rst_wr", 32'(fifo_wr_en), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_gid", 32'(grant_id), 0);
        chk("mid_rst_stat", 32'(stat_beats), 0);
        model_reset();
      end else begin
        model_step(rdp);
      end
    end

    // after reset, a lone request from producer 2 wins first
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'hA5;
    #1;
    chk("dir_idle_busy", 32'(busy), 0);
    chk("dir_idle_wr", 32'(fifo_wr_en), 0);
    @(posedge clk);
    #1;
    chk("dir_gid", 32'(grant_id), 2);
    chk("dir_busy", 32'(busy), 1);
    chk("dir_wr", 32'(fifo_wr_en), 1);
    chk("dir_data", 32'(fifo_data_in), 32'hA5);
    chk("dir_ready", 32'(req_ready), 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
